// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: matches ACE snoops against programmable rules and answers with a
// per-rule CRRESP after a per-rule delay, optionally followed by a planted cache line on CD.
module ace_snoop_responder #(
  parameter int ADDR_W = 44,
  parameter int DATA_W = 128,
  parameter int LINE_B = 64,
  parameter int NRULES = 4,
  parameter int DLY_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     ace_aclk,
  input  logic                     ace_aresetn,
  input  logic                     acvalid,
  output logic                     acready,
  input  logic [ADDR_W-1:0]        acaddr,
  input  logic [3:0]               acsnoop,
  output logic                     crvalid,
  input  logic                     crready,
  output logic [4:0]               crresp,
  output logic                     cdvalid,
  input  logic                     cdready,
  output logic [DATA_W-1:0]        cddata,
  output logic                     cdlast,
  input  logic                     cfg_en,
  input  logic [NRULES-1:0]        cfg_rule_en,
  input  logic [NRULES-1:0]        cfg_addrflt,
  input  logic [NRULES-1:0]        cfg_acflt,
  input  logic [NRULES*ADDR_W-1:0] cfg_base,
  input  logic [NRULES*ADDR_W-1:0] cfg_size,
  input  logic [NRULES*4-1:0]      cfg_acsnoop,
  input  logic [NRULES*5-1:0]      cfg_crresp,
  input  logic [NRULES*DLY_W-1:0]  cfg_delay,
  input  logic [LINE_B*8-1:0]      cfg_line,
  input  logic                     cnt_clr,
  output logic [NRULES*CNT_W-1:0]  match_cnt,
  output logic                     busy,
  output logic [3:0]               last_hit
);
  localparam int BEATS = LINE_B * 8 / DATA_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, DELAY, RESP, DATA} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          snoop_q;
  logic                en_q;
  logic [4:0]          resp_q;
  logic [DLY_W-1:0]    dly_q;
  logic                data_q;
  logic [BW-1:0]       beat_q;
  logic [LINE_B*8-1:0] line_q;
  logic [CNT_W-1:0]    cnt [NRULES];
  logic [NRULES-1:0]   rule_hit, win;
  logic                any_hit;
  logic [2:0]          sel_idx;
  logic [4:0]          sel_resp;
  logic [DLY_W-1:0]    sel_dly;
  logic                ac_hs, cr_hs, cd_hs;

  // Window end is formed one bit wider so base+size never wraps.
  for (genvar r = 0; r < NRULES; r++) begin : g_rule
    logic [ADDR_W:0] lo, hi, a;
    assign lo = {1'b0, cfg_base[r*ADDR_W +: ADDR_W]};
    assign hi = lo + {1'b0, cfg_size[r*ADDR_W +: ADDR_W]};
    assign a  = {1'b0, addr_q};
    assign rule_hit[r] = en_q && cfg_rule_en[r]
                         && (!cfg_addrflt[r] || (a >= lo && a < hi))
                         && (!cfg_acflt[r] || snoop_q == cfg_acsnoop[r*4 +: 4]);
    assign match_cnt[r*CNT_W +: CNT_W] = cnt[r];
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    any_hit = |rule_hit;
    sel_idx = '0;
    sel_resp = '0;
    sel_dly = '0;
    win = '0;
    for (int i = NRULES - 1; i >= 0; i--)
      if (rule_hit[i]) begin
        sel_idx = 3'(i);
        sel_resp = cfg_crresp[i*5 +: 5];
        sel_dly = cfg_delay[i*DLY_W +: DLY_W];
        win = '0;
        win[i] = 1'b1;
      end
  end

  assign ac_hs = state == IDLE && acvalid;
  assign cr_hs = state == RESP && crready;
  assign cd_hs = state == DATA && cdready;

  always_ff @(posedge ace_aclk or negedge ace_aresetn)
    if (!ace_aresetn) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ac_hs ? LOOKUP : IDLE;
      LOOKUP:  state_nx = sel_dly != '0 ? DELAY : RESP;
      DELAY:   state_nx = dly_q == DLY_W'(1) ? RESP : DELAY;
      RESP:    state_nx = cr_hs ? (data_q ? DATA : IDLE) : RESP;
      DATA:    state_nx = cd_hs && beat_q == LAST_BEAT ? IDLE : DATA;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    acready = state == IDLE;
    busy = state != IDLE;
    crvalid = state == RESP;
    crresp = crvalid ? resp_q : '0;
    cdvalid = state == DATA;
    cddata = cdvalid ? line_q[beat_q*DATA_W +: DATA_W] : '0;
    cdlast = cdvalid && beat_q == LAST_BEAT;
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn)
    if (!ace_aresetn) begin
      addr_q <= '0;
      snoop_q <= '0;
      en_q <= 1'b0;
      resp_q <= '0;
      dly_q <= '0;
      data_q <= 1'b0;
      beat_q <= '0;
      line_q <= '0;
      last_hit <= '0;
    end else begin
      if (ac_hs) begin
        addr_q <= acaddr;
        snoop_q <= acsnoop;
        en_q <= cfg_en;
      end
      if (state == LOOKUP) begin
        resp_q <= sel_resp;
        dly_q <= sel_dly;
        data_q <= any_hit && sel_resp[0];
        last_hit <= {any_hit, sel_idx};
      end
      if (state == DELAY) dly_q <= dly_q - DLY_W'(1);
      if (cr_hs) begin
        line_q <= cfg_line;
        beat_q <= '0;
      end
      if (cd_hs) beat_q <= beat_q + BW'(1);
    end

  always_ff @(posedge ace_aclk or negedge ace_aresetn)
    if (!ace_aresetn) begin
      for (int i = 0; i < NRULES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NRULES; i++)
        if (cnt_clr) cnt[i] <= '0;
        else if (state == LOOKUP && win[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: scoreboard bench; expected CR/CD traffic is queued when a snoop is issued.
module tb_ace_snoop_responder;
  localparam int AW = 44, DW = 128, NR = 4, CW = 8, BEATS = 4;

  logic tb_clk = 1'b0;
  logic rst_n;
  logic acvalid, acready, crvalid, crready, cdvalid, cdready, cdlast;
  logic [AW-1:0] acaddr;
  logic [3:0] acsnoop, last_hit;
  logic [4:0] crresp;
  logic [DW-1:0] cddata;
  logic cfg_en, cnt_clr, busy;
  logic [NR-1:0] cfg_rule_en, cfg_addrflt, cfg_acflt;
  logic [NR*AW-1:0] cfg_base, cfg_size;
  logic [NR*4-1:0] cfg_acsnoop;
  logic [NR*5-1:0] cfg_crresp;
  logic [NR*8-1:0] cfg_delay;
  logic [511:0] cfg_line;
  logic [NR*CW-1:0] match_cnt;

  int cyc = 0;
  int n_chk = 0, n_err = 0;
  logic [4:0] cr_q[$];
  logic [DW:0] cd_q[$];
  logic cr_stall = 1'b0, cd_stall = 1'b0;
  logic [4:0] cr_prev;
  logic [DW:0] cd_prev;

  ace_snoop_responder #(.ADDR_W(AW), .DATA_W(DW), .LINE_B(64), .NRULES(NR), .DLY_W(8), .CNT_W(CW)) dut (
    .ace_aclk(tb_clk), .ace_aresetn(rst_n),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .cfg_en(cfg_en), .cfg_rule_en(cfg_rule_en), .cfg_addrflt(cfg_addrflt), .cfg_acflt(cfg_acflt),
    .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_acsnoop(cfg_acsnoop), .cfg_crresp(cfg_crresp),
    .cfg_delay(cfg_delay), .cfg_line(cfg_line), .cnt_clr(cnt_clr), .match_cnt(match_cnt),
    .busy(busy), .last_hit(last_hit)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: pops on each handshake and checks that stalled payloads hold still.
  always @(negedge tb_clk) begin
    if (!rst_n) begin
      cr_stall <= 1'b0;
      cd_stall <= 1'b0;
    end else begin
      if (cr_stall) check("cr_hold", {crvalid, crresp}, {1'b1, cr_prev});
      if (cd_stall) check("cd_hold", {cdvalid, cdlast, cddata}, {1'b1, cd_prev});
      if (crvalid && crready) begin
        if (cr_q.size() == 0) check("cr_extra", 1, 0);
        else check("crresp", crresp, cr_q.pop_front());
      end
      if (cdvalid && cdready) begin
        if (cd_q.size() == 0) check("cd_extra", 1, 0);
        else check("cd_beat", {cdlast, cddata}, cd_q.pop_front());
      end
      cr_stall <= crvalid && !crready;
      cr_prev <= crresp;
      cd_stall <= cdvalid && !cdready;
      cd_prev <= {cdlast, cddata};
    end
  end

  task automatic set_rule(input int i, input bit en, input bit af, input bit cf,
                          input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic [3:0] op, input logic [4:0] rs, input logic [7:0] d);
    cfg_rule_en[i] = en;
    cfg_addrflt[i] = af;
    cfg_acflt[i] = cf;
    cfg_base[i*AW +: AW] = b;
    cfg_size[i*AW +: AW] = s;
    cfg_acsnoop[i*4 +: 4] = op;
    cfg_crresp[i*5 +: 5] = rs;
    cfg_delay[i*8 +: 8] = d;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge tb_clk);
      ok = acready;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  // Handshakes one snoop, queues its expected traffic and checks when crvalid first rises.
  task automatic issue(input logic [AW-1:0] a, input logic [3:0] op, input logic [4:0] r,
                       input bit d, input int dly);
    int t0;
    bit seen = 1'b0;
    wait_idle();
    acaddr = a;
    acsnoop = op;
    acvalid = 1'b1;
    t0 = cyc;
    cr_q.push_back(r);
    if (d) for (int k = 0; k < BEATS; k++) cd_q.push_back({k == BEATS - 1, cfg_line[k*DW +: DW]});
    @(posedge tb_clk);
    #1 acvalid = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge tb_clk);
      seen = crvalid;
    end
    check("cr_cycle", cyc - t0, 2 + dly);
  endtask

  initial begin
    bit hit2 = 1'b0;
    rst_n = 1'b0;
    acvalid = 1'b0; acaddr = '0; acsnoop = '0;
    crready = 1'b1; cdready = 1'b1; cnt_clr = 1'b0;
    cfg_en = 1'b0; cfg_rule_en = '0; cfg_addrflt = '0; cfg_acflt = '0;
    cfg_base = '0; cfg_size = '0; cfg_acsnoop = '0; cfg_crresp = '0; cfg_delay = '0;
    for (int k = 0; k < 16; k++) cfg_line[k*32 +: 32] = $urandom;
    repeat (3) @(negedge tb_clk);
    rst_n = 1'b1;
    @(negedge tb_clk);
    check("rst_ctl", {acready, crvalid, cdvalid, cdlast, busy}, 5'b10000);
    check("rst_data", {crresp, cddata, last_hit}, '0);
    check("rst_cnt", match_cnt, '0);

    // Opcode-filtered window hit with a full line
    cfg_en = 1'b1;
    set_rule(0, 1, 1, 1, 44'h4000_0000, 44'h40, 4'd1, 5'h01, 8'd0);
    issue(44'h4000_0020, 4'd1, 5'h01, 1, 0);
    wait_idle();
    check("t1_cnt0", match_cnt[0 +: CW], 1);
    check("t1_last", last_hit, 4'h8);
    issue(44'h4000_0020, 4'd0, 5'h00, 0, 0);
    wait_idle();
    check("t2_cnt0", match_cnt[0 +: CW], 1);
    check("t2_last", last_hit, 4'h0);

    // Window edges
    set_rule(0, 1, 1, 0, 44'h100, 44'h100, 4'd0, 5'h02, 8'd0);
    issue(44'h1FF, 4'd3, 5'h02, 0, 0);
    wait_idle();
    check("win_1ff_last", last_hit, 4'h8);
    issue(44'h200, 4'd3, 5'h00, 0, 0);
    wait_idle();
    check("win_200_last", last_hit, 4'h0);
    issue(44'h100, 4'd3, 5'h02, 0, 0);
    issue(44'hFF, 4'd3, 5'h00, 0, 0);
    set_rule(0, 1, 1, 0, 44'h100, 44'h0, 4'd0, 5'h02, 8'd0);
    issue(44'h100, 4'd3, 5'h00, 0, 0);
    wait_idle();
    check("size0_last", last_hit, 4'h0);
    check("win_cnt0", match_cnt[0 +: CW], 3);

    // Priority and delay
    set_rule(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rule(1, 1, 0, 0, 0, 0, 4'd0, 5'h04, 8'd5);
    set_rule(2, 1, 0, 0, 0, 0, 4'd0, 5'h08, 8'd2);
    issue(44'h1234, 4'd7, 5'h04, 0, 5);
    wait_idle();
    check("prio_last", last_hit, 4'h9);
    check("prio_cnt1", match_cnt[CW +: CW], 1);
    check("prio_cnt2", match_cnt[2*CW +: CW], 0);
    cfg_rule_en[1] = 1'b0;
    issue(44'h1234, 4'd7, 5'h08, 0, 2);
    wait_idle();
    check("r2_last", last_hit, 4'hA);
    check("r2_cnt2", match_cnt[2*CW +: CW], 1);
    cfg_en = 1'b0;
    issue(44'h1234, 4'd7, 5'h00, 0, 0);
    wait_idle();
    check("dis_last", last_hit, 4'h0);
    check("dis_cnt2", match_cnt[2*CW +: CW], 1);
    cfg_en = 1'b1;

    // Backpressure on both channels
    set_rule(1, 1, 0, 0, 0, 0, 4'd0, 5'h01, 8'd0);
    set_rule(2, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge tb_clk);
    #1 crready = 1'b0;
    issue(44'h80, 4'd2, 5'h01, 1, 0);
    repeat (2) begin
      @(posedge tb_clk);
      #1 check("bp_cr_ac", {acready, crvalid}, 2'b01);
    end
    @(posedge tb_clk);
    #1 crready = 1'b1;
    cdready = 1'b0;
    repeat (10) begin
      @(posedge tb_clk);
      #1 cdready = ~cdready;
      if (cdvalid) check("bp_cd_ac", acready, 0);
    end
    cdready = 1'b1;
    wait_idle();
    check("bp_cnt1", match_cnt[CW +: CW], 2);

    // Asynchronous reset during beat 2
    issue(44'h80, 4'd2, 5'h01, 1, 0);
    for (int i = 0; i < 20 && !hit2; i++) begin
      @(negedge tb_clk);
      hit2 = cdvalid && cddata == cfg_line[2*DW +: DW];
    end
    check("beat2_seen", hit2, 1);
    #1 rst_n = 1'b0;
    #1 check("arst_ctl", {acready, crvalid, cdvalid, cdlast, busy}, 5'b10000);
    check("arst_data", {crresp, cddata, last_hit}, '0);
    check("arst_cnt", match_cnt, '0);
    cr_q.delete();
    cd_q.delete();
    @(negedge tb_clk);
    rst_n = 1'b1;

    // Saturation, clear, and clear-over-increment
    set_rule(1, 1, 0, 0, 0, 0, 4'd0, 5'h02, 8'd0);
    repeat (255) issue(44'h40, 4'd0, 5'h02, 0, 0);
    wait_idle();
    check("sat_fill", match_cnt[CW +: CW], 8'hFF);
    issue(44'h40, 4'd0, 5'h02, 0, 0);
    wait_idle();
    check("sat_hold", match_cnt[CW +: CW], 8'hFF);
    cnt_clr = 1'b1;
    @(negedge tb_clk);
    cnt_clr = 1'b0;
    check("clr", match_cnt[CW +: CW], 0);
    cnt_clr = 1'b1;
    issue(44'h40, 4'd0, 5'h02, 0, 0);
    check("clr_prio", match_cnt[CW +: CW], 0);
    cnt_clr = 1'b0;
    wait_idle();
    check("clr_after", match_cnt[CW +: CW], 0);
    check("clr_last", last_hit, 4'h9);

    repeat (3) @(negedge tb_clk);
    check("sb_empty", cr_q.size() + cd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
